// File: rtl/music_sequencer_if.sv
// Control and note-ROM bus between the player front end and the song sequencer.
interface music_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic              play;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_q;
    logic [3:0]        note_out;
    logic              playing;
    logic              beat_tick;
    logic              song_done;

    modport master (
        output play, stop, loop_en, rom_q,
        input  rom_addr, note_out, playing, beat_tick, song_done
    );

    modport slave (
        input  play, stop, loop_en, rom_q,
        output rom_addr, note_out, playing, beat_tick, song_done
    );
endinterface

// File: rtl/music_sequencer.sv
// Beat-timed song sequencer: walks the note ROM one note per beat with
// play/pause/stop, optional looping and a short rest between repeated notes.
module music_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int SONG_LEN = 139,
    parameter int TICK_DIV = 250000,
    parameter int GAP_CYC  = 25000
) (
    input  logic               clk,
    input  logic               rst_n,
    music_sequencer_if.slave   bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCH2 = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        cur_q, cur_d;
    logic              pend_q, pend_d;
    logic              tick;
    logic              last;

    assign tick = (state_q == S_PLAY) && (cnt_q == CW'(TICK_DIV - 1));
    assign last = (addr_q == ADDR_W'(SONG_LEN - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        // Fetch cycles belong to the beat, so the counter runs through them.
        if (state_q == S_FETCH1 || state_q == S_FETCH2 || state_q == S_PLAY)
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.play) begin
                    state_d = S_FETCH1;
                    addr_d  = '0;
                end
            end
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                cur_d = bus.rom_q;
                if (bus.rom_q == prev_q && bus.rom_q != 4'd0)
                    gap_d = GW'(GAP_CYC);
                state_d = pend_q ? S_PAUSE : S_PLAY;
                pend_d  = 1'b0;
            end
            S_PLAY: begin
                if (gap_q != '0)
                    gap_d = gap_q - GW'(1);
                if (tick) begin
                    prev_d  = cur_q;
                    gap_d   = '0;
                    pend_d  = bus.play;
                    state_d = S_FETCH1;
                    if (!last) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        addr_d = '0;
                        if (!bus.loop_en) begin
                            state_d = S_IDLE;
                            prev_d  = '0;
                            pend_d  = 1'b0;
                        end
                    end
                end else if (bus.play) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.play)
                    state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
            gap_d   = '0;
            prev_d  = '0;
            cur_d   = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.playing   = (state_q == S_FETCH1) || (state_q == S_FETCH2) ||
                           (state_q == S_PLAY);
    assign bus.note_out  = (state_q == S_PLAY && gap_q == '0) ? cur_q : 4'd0;
    assign bus.beat_tick = tick;
    assign bus.song_done = tick && last && !bus.stop;
endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a beat-position reference model.
module tb_music_sequencer;
    localparam int TD = 10;
    localparam int SL = 4;
    localparam int GC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    music_sequencer_if #(.ADDR_W(8)) bus ();

    music_sequencer #(
        .ADDR_W(8), .SONG_LEN(SL), .TICK_DIV(TD), .GAP_CYC(GC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [3:0] rom [4];
    int checks = 0;
    int errors = 0;

    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr[1:0]];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: mode 0 idle, 1 running, 2 paused; pos = cycles into the beat
    int m_mode = 0;
    int m_addr = 0;
    int m_pos = 0;
    int m_prev = 0;
    bit m_rep = 0;
    bit m_pend = 0;
    bit m_valid = 0;

    initial forever begin
        int e_note, e_tick, e_done, silent;
        @(negedge clk);
        if (m_valid) begin
            e_tick = (m_mode == 1 && m_pos == TD - 1) ? 1 : 0;
            e_done = (e_tick == 1 && m_addr == SL - 1 && !bus.stop) ? 1 : 0;
            silent = m_rep ? GC : 0;
            e_note = 0;
            if (m_mode == 1 && m_pos >= 2 && (m_pos - 2) >= silent)
                e_note = rom[m_addr];
            chk("rom_addr", bus.rom_addr, m_addr);
            chk("note_out", bus.note_out, e_note);
            chk("playing", bus.playing, m_mode == 1 ? 1 : 0);
            chk("beat_tick", bus.beat_tick, e_tick);
            chk("song_done", bus.song_done, e_done);
        end
        if (!rst_n || bus.stop) begin
            m_mode = 0; m_addr = 0; m_pos = 0; m_prev = 0;
            m_rep = 0; m_pend = 0; m_valid = 1;
        end else if (m_mode == 0) begin
            if (bus.play) begin
                m_mode = 1; m_addr = 0; m_pos = 0; m_pend = 0;
            end
        end else if (m_mode == 2) begin
            if (bus.play) m_mode = 1;
        end else if (m_pos == TD - 1) begin
            m_prev = rom[m_addr];
            m_pend = bus.play;
            m_pos = 0;
            if (m_addr < SL - 1) begin
                m_addr++;
            end else begin
                m_addr = 0;
                if (!bus.loop_en) begin
                    m_mode = 0; m_prev = 0; m_pend = 0;
                end
            end
        end else if (m_pos < 2) begin
            m_pos++;
            if (m_pos == 2) begin
                m_rep = (rom[m_addr] == m_prev[3:0]) && (rom[m_addr] != 0);
                if (m_pend) begin
                    m_mode = 2; m_pend = 0;
                end
            end
        end else begin
            m_pos++;
            if (bus.play) m_mode = 2;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
    endtask

    initial begin
        rom[0] = 4'd5; rom[1] = 4'd5; rom[2] = 4'd0; rom[3] = 4'd7;
        bus.rom_q = 4'd0;
        bus.play = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        cyc(2);
        chk("rst_note", bus.note_out, 0);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_playing", bus.playing, 0);
        rst_n = 1'b1;
        cyc(1);

        // full song, no loop
        pulse_play();
        chk("s1_playing", bus.playing, 1);
        cyc(2);
        chk("s1_note_a0", bus.note_out, 5);
        cyc(7);
        chk("s1_tick_a0", bus.beat_tick, 1);
        cyc(1);
        chk("s1_addr1", bus.rom_addr, 1);
        cyc(2);
        chk("s1_gap", bus.note_out, 0);
        cyc(3);
        chk("s1_after_gap", bus.note_out, 5);
        cyc(5);
        chk("s1_addr2", bus.rom_addr, 2);
        cyc(12);
        chk("s1_note_a3", bus.note_out, 7);
        cyc(7);
        chk("s1_done", bus.song_done, 1);
        cyc(1);
        chk("s1_idle_playing", bus.playing, 0);
        chk("s1_idle_addr", bus.rom_addr, 0);
        cyc(3);

        // pause and resume inside addr 1
        pulse_play();
        cyc(15);
        pulse_play();
        chk("s2_paused_note", bus.note_out, 0);
        chk("s2_paused_play", bus.playing, 0);
        cyc(19);
        chk("s2_still_addr1", bus.rom_addr, 1);
        pulse_play();
        chk("s2_resumed", bus.beat_tick, 0);
        cyc(3);
        chk("s2_tick", bus.beat_tick, 1);
        cyc(1);
        chk("s2_addr2", bus.rom_addr, 2);
        cyc(5);
        bus.stop = 1'b1;
        bus.play = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        bus.play = 1'b0;
        chk("s2_stop_playing", bus.playing, 0);
        chk("s2_stop_addr", bus.rom_addr, 0);
        chk("s2_stop_done", bus.song_done, 0);
        cyc(2);

        // looping, pause requested on a beat boundary
        bus.loop_en = 1'b1;
        pulse_play();
        cyc(39);
        chk("s3_done", bus.song_done, 1);
        cyc(1);
        chk("s3_wrap_addr", bus.rom_addr, 0);
        chk("s3_wrap_playing", bus.playing, 1);
        cyc(2);
        chk("s3_wrap_nogap", bus.note_out, 5);
        cyc(7);
        pulse_play();
        cyc(2);
        chk("s3_pend_pause", bus.playing, 0);
        cyc(3);
        pulse_play();
        chk("s3_resume_gap", bus.note_out, 0);
        cyc(3);
        chk("s3_resume_note", bus.note_out, 5);
        cyc(5);
        pulse_play();
        cyc(1);
        chk("s3_fetch_play_ign", bus.playing, 1);

        // reset while paused
        pulse_play();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("s4_rst_addr", bus.rom_addr, 0);
        chk("s4_rst_playing", bus.playing, 0);
        bus.loop_en = 1'b0;
        pulse_play();
        chk("s4_restart", bus.rom_addr, 0);
        cyc(2);
        chk("s4_note", bus.note_out, 5);
        cyc(45);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
